multicycle_ctrl: RTL and testbench

Multicycle control unit for the RV32I core. It sequences the shared datapath (register file, immediate generator, ALU, PC, instruction register and the single shared memory port) through fetch, decode, execute, memory and writeback states. All datapath mux selects and write enables are driven from this block, keyed on the opcode held in the instruction register.

---
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of the shared datapath.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal_instr) instead of acting as NOP.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [2:0] state_o,
  output logic       illegal_instr
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [2:0] state, state_nxt;
  logic       known;

  always_comb begin
    known = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    alu_op    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    state_o   = state;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (known) begin
          state_nxt = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          pc_we     = 1'b1;
          state_nxt = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        state_nxt = S_WB;
        case (opcode)
          OP_R: alu_op = 2'd1;
          OP_I: begin alu_b_sel = 1'b1; alu_op = 2'd1; end
          OP_LUI: begin alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
          OP_AUIPC: begin alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
          OP_LOAD, OP_STORE: begin alu_b_sel = 1'b1; state_nxt = S_MEM; end
          OP_BRANCH: begin
            alu_op    = 2'd2;
            pc_we     = 1'b1;
            pc_sel    = branch_taken ? 2'd1 : 2'd0;
            state_nxt = S_FETCH;
          end
          OP_JAL: begin
            reg_we = 1'b1; wb_sel = 2'd2; pc_we = 1'b1; pc_sel = 2'd1;
            state_nxt = S_FETCH;
          end
          OP_JALR: begin
            alu_b_sel = 1'b1;
            reg_we = 1'b1; wb_sel = 2'd2; pc_we = 1'b1; pc_sel = 2'd2;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        // ALU keeps forming rs1+imm so the address stays stable across wait cycles
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_we    = (opcode == OP_STORE);
        alu_b_sel = 1'b1;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
        pc_we     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
    if (rst) begin
      mem_req = 1'b0; mem_we = 1'b0; iord = 1'b0; ir_we = 1'b0; pc_we = 1'b0;
      pc_sel = 2'd0; alu_a_sel = 2'd0; alu_b_sel = 1'b0; alu_op = 2'd0;
      reg_we = 1'b0; wb_sel = 2'd0; state_o = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

`ifdef ILLEGAL_TRAP_EN
  logic ill_q, ill_set;
  assign ill_set       = (state == S_DECODE) && !known;
  assign illegal_instr = !rst && (ill_q || ill_set);

  always_ff @(posedge clk) begin
    if (rst) ill_q <= 1'b0;
    else     ill_q <= ill_q | ill_set;
  end
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected output traces built from the instruction-class rules.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst, mem_ready, branch_taken;
  logic [6:0] opcode;
  logic       mem_req, mem_we, iord, ir_we, pc_we, alu_b_sel, reg_we, illegal_instr;
  logic [1:0] pc_sel, alu_a_sel, alu_op, wb_sel;
  logic [2:0] state_o;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .state_o(state_o), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] SB = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b1111111;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_sel, alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [2:0] state;
    logic       ill;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic       rdy, tk;
    outs_t      o;
  } step_t;

  step_t tr[$];
  outs_t obs[$];
  int    nvec = 0, nerr = 0;

  function automatic outs_t blank(logic [2:0] s);
    outs_t o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic outs_t cur();
    outs_t o;
    o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord; o.ir_we = ir_we;
    o.pc_we = pc_we; o.pc_sel = pc_sel; o.alu_a_sel = alu_a_sel; o.alu_b_sel = alu_b_sel;
    o.alu_op = alu_op; o.reg_we = reg_we; o.wb_sel = wb_sel; o.state = state_o;
    o.ill = illegal_instr;
    return o;
  endfunction

  function automatic void add(logic [6:0] op, logic rdy, logic tk, outs_t o);
    step_t s;
    s.op = op; s.rdy = rdy; s.tk = tk; s.o = o;
    tr.push_back(s);
  endfunction

  // Expected per-cycle trace of one instruction; inputs are random wherever they must not matter.
  function automatic void build(logic [6:0] op, int fw, int mw, logic tk);
    outs_t o;
    tr.delete();
    for (int i = 0; i <= fw; i++) begin
      o = blank(3'd0); o.mem_req = 1'b1; o.ir_we = (i == fw);
      add(7'($urandom), (i == fw), 1'($urandom), o);
    end
    o = blank(3'd1);
    if (!(op inside {R, I, LD, ST, SB, JAL, JALR, LUI, AUIPC})) begin
`ifdef ILLEGAL_TRAP_EN
      o.ill = 1'b1;
      add(op, 1'($urandom), 1'($urandom), o);
      repeat (4) begin
        o = blank(3'd5); o.ill = 1'b1;
        add(op, 1'($urandom), 1'($urandom), o);
      end
`else
      o.pc_we = 1'b1;
      add(op, 1'($urandom), 1'($urandom), o);
`endif
      return;
    end
    add(op, 1'($urandom), 1'($urandom), o);
    o = blank(3'd2);
    case (op)
      R:     o.alu_op = 2'd1;
      I:     begin o.alu_b_sel = 1'b1; o.alu_op = 2'd1; end
      LUI:   begin o.alu_a_sel = 2'd2; o.alu_b_sel = 1'b1; end
      AUIPC: begin o.alu_a_sel = 2'd1; o.alu_b_sel = 1'b1; end
      LD, ST: o.alu_b_sel = 1'b1;
      SB:    begin o.alu_op = 2'd2; o.pc_we = 1'b1; o.pc_sel = tk ? 2'd1 : 2'd0; end
      JAL:   begin o.reg_we = 1'b1; o.wb_sel = 2'd2; o.pc_we = 1'b1; o.pc_sel = 2'd1; end
      default: begin
        o.alu_b_sel = 1'b1; o.reg_we = 1'b1; o.wb_sel = 2'd2; o.pc_we = 1'b1; o.pc_sel = 2'd2;
      end
    endcase
    add(op, 1'($urandom), (op == SB) ? tk : 1'($urandom), o);
    if (op == LD || op == ST) begin
      for (int i = 0; i <= mw; i++) begin
        o = blank(3'd3); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (op == ST);
        o.alu_b_sel = 1'b1; o.pc_we = (op == ST) && (i == mw);
        add(op, (i == mw), 1'($urandom), o);
      end
    end
    if (op inside {R, I, LUI, AUIPC, LD}) begin
      o = blank(3'd4); o.reg_we = 1'b1; o.wb_sel = (op == LD) ? 2'd1 : 2'd0; o.pc_we = 1'b1;
      add(op, 1'($urandom), 1'($urandom), o);
    end
  endfunction

  // Applies the first n steps of the trace (all if n < 0) and records what the DUT drove.
  task automatic run_trace(input int n);
    int lim = (n < 0) ? tr.size() : n;
    obs.delete();
    for (int i = 0; i < lim; i++) begin
      opcode = tr[i].op; mem_ready = tr[i].rdy; branch_taken = tr[i].tk;
      @(negedge clk);
      obs.push_back(cur());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    outs_t e;
    rst = 1'b1; mem_ready = 1'b1; opcode = R;
    @(negedge clk);
    nvec++;
    if (cur() !== '0) begin nerr++; $display("FAIL reset_outputs got %h exp 0", cur()); end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    e = blank(3'd0); e.mem_req = 1'b1;
    nvec++;
    if (cur() !== e) begin nerr++; $display("FAIL reset_exit got %h exp %h", cur(), e); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [2:0] seq [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    build(R, 0, 0, 1'b0);
    run_trace(-1);
    for (int i = 0; i < obs.size(); i++) begin
      nvec++;
      if (obs[i] !== tr[i].o) begin nerr++; $display("FAIL add cyc %0d got %h exp %h", i, obs[i], tr[i].o); end
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (obs[i].state !== seq[i]) begin nerr++; $display("FAIL add_state cyc %0d got %0d exp %0d", i, obs[i].state, seq[i]); end
    end
  endtask

  task automatic test_load_wait();
    int nreq = 0;
    build(LD, 0, 2, 1'b0);
    run_trace(-1);
    for (int i = 0; i < obs.size(); i++) begin
      nvec++;
      if (obs[i] !== tr[i].o) begin nerr++; $display("FAIL load cyc %0d got %h exp %h", i, obs[i], tr[i].o); end
      if (obs[i].mem_req && obs[i].iord) nreq++;
    end
    nvec++;
    if (nreq !== 3) begin nerr++; $display("FAIL load_mem_cycles got %0d exp 3", nreq); end
    nvec++;
    if (obs[6].state !== 3'd4 || obs[6].wb_sel !== 2'd1)
      begin nerr++; $display("FAIL load_wb got st %0d wb %0d exp st 4 wb 1", obs[6].state, obs[6].wb_sel); end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      build(SB, 0, 0, t[0]);
      run_trace(-1);
      for (int i = 0; i < obs.size(); i++) begin
        nvec++;
        if (obs[i] !== tr[i].o) begin nerr++; $display("FAIL branch tk %0d cyc %0d got %h exp %h", t, i, obs[i], tr[i].o); end
      end
      nvec++;
      if (obs[2].pc_sel !== 2'(t) || obs[2].pc_we !== 1'b1 || obs[2].reg_we !== 1'b0)
        begin nerr++; $display("FAIL branch_exec tk %0d got pc_sel %0d pc_we %b reg_we %b exp %0d 1 0", t, obs[2].pc_sel, obs[2].pc_we, obs[2].reg_we, t); end
    end
  endtask

  task automatic test_jalr();
    build(JALR, 1, 0, 1'b0);
    run_trace(-1);
    for (int i = 0; i < obs.size(); i++) begin
      nvec++;
      if (obs[i] !== tr[i].o) begin nerr++; $display("FAIL jalr cyc %0d got %h exp %h", i, obs[i], tr[i].o); end
    end
    nvec++;
    if (obs[3].reg_we !== 1'b1 || obs[3].wb_sel !== 2'd2 || obs[3].pc_sel !== 2'd2 ||
        obs[3].alu_a_sel !== 2'd0 || obs[3].alu_b_sel !== 1'b1)
      begin nerr++; $display("FAIL jalr_exec got %h", obs[3]); end
  endtask

  task automatic test_reset_mid_mem();
    outs_t e;
    build(ST, 0, 2, 1'b0);
    run_trace(4);
    for (int i = 0; i < obs.size(); i++) begin
      nvec++;
      if (obs[i] !== tr[i].o) begin nerr++; $display("FAIL rstmem cyc %0d got %h exp %h", i, obs[i], tr[i].o); end
    end
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (cur() !== '0) begin nerr++; $display("FAIL rstmem_rst got %h exp 0", cur()); end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    e = blank(3'd0); e.mem_req = 1'b1;
    nvec++;
    if (cur() !== e) begin nerr++; $display("FAIL rstmem_after got %h exp %h", cur(), e); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    outs_t e;
    build(BAD, 0, 0, 1'b0);
    run_trace(-1);
    for (int i = 0; i < obs.size(); i++) begin
      nvec++;
      if (obs[i] !== tr[i].o) begin nerr++; $display("FAIL illegal cyc %0d got %h exp %h", i, obs[i], tr[i].o); end
    end
`ifdef ILLEGAL_TRAP_EN
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (cur() !== '0) begin nerr++; $display("FAIL trap_rst got %h exp 0", cur()); end
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    mem_ready = 1'b0;
    @(negedge clk);
    e = blank(3'd0); e.mem_req = 1'b1;
    nvec++;
    if (cur() !== e) begin nerr++; $display("FAIL illegal_next got %h exp %h", cur(), e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
`ifdef ILLEGAL_TRAP_EN
    logic [6:0] ops [9] = '{R, I, LD, ST, SB, JAL, JALR, LUI, AUIPC};
`else
    logic [6:0] ops [10] = '{R, I, LD, ST, SB, JAL, JALR, LUI, AUIPC, BAD};
`endif
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op = ops[$urandom_range($size(ops) - 1)];
      build(op, $urandom_range(3), $urandom_range(3), 1'($urandom));
      run_trace(-1);
      for (int i = 0; i < obs.size(); i++) begin
        nvec++;
        if (obs[i] !== tr[i].o) begin nerr++; $display("FAIL b2b instr %0d op %b cyc %0d got %h exp %h", n, op, i, obs[i], tr[i].o); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jalr();
    test_reset_mid_mem();
    test_back_to_back();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
